// File: rtl/bar_acc_pipe.sv
// bar_acc_pipe: multi-channel registered adder/accumulator feeding a DEPTH-stage stallable pipeline.
// Build option BAR_ACC_PIPE_SATURATE_EN clamps carry-out results (and mode-1 accumulators) to all-ones.
module bar_acc_pipe #(
  parameter int  WIDTH     = 8,
  parameter int  CHANNELS  = 4,
  parameter int  INCREMENT = 5,
  parameter int  DEPTH     = 2,
  localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [CW-1:0]    in_chan,
  input  logic [WIDTH-1:0] inp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_chan,
  output logic [WIDTH-1:0] out,
  output logic             out_ovf
);

  localparam logic [WIDTH-1:0] INC = WIDTH'(INCREMENT);

  logic             stall_s;
  logic             accept_s;
  logic             chan_ok_s;
  logic             acc_mode_s;
  logic [WIDTH-1:0] acc_rd_s;
  logic [WIDTH-1:0] op_a_s;
  logic [WIDTH-1:0] op_b_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] res_d;
  logic             ovf_d;

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [CW-1:0]    chan_q [DEPTH];
  logic             ovf_q  [DEPTH];
  logic [WIDTH-1:0] acc_q  [CHANNELS];

  assign stall_s   = valid_q[DEPTH-1] & ~out_ready;
  assign in_ready  = ~stall_s & ~clr & rst;
  assign accept_s  = in_valid & in_ready;

  assign out_valid = valid_q[DEPTH-1];
  assign out       = data_q[DEPTH-1];
  assign out_chan  = chan_q[DEPTH-1];
  assign out_ovf   = ovf_q[DEPTH-1];

  // Stage-0 arithmetic; an out-of-range channel falls back to the increment path.
  always_comb begin
    chan_ok_s  = ({1'b0, in_chan} < (CW+1)'(CHANNELS));
    acc_mode_s = in_mode & chan_ok_s;
    acc_rd_s   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      acc_rd_s = (in_chan == CW'(c)) ? acc_q[c] : acc_rd_s;
    end
    if (acc_mode_s) begin
      op_a_s = acc_rd_s;
      op_b_s = inp;
    end else begin
      op_a_s = inp;
      op_b_s = INC;
    end
    sum_s = {1'b0, op_a_s} + {1'b0, op_b_s};
    ovf_d = sum_s[WIDTH];
`ifdef BAR_ACC_PIPE_SATURATE_EN
    if (sum_s[WIDTH]) begin
      res_d = {WIDTH{1'b1}};
    end else begin
      res_d = sum_s[WIDTH-1:0];
    end
`else
    res_d = sum_s[WIDTH-1:0];
`endif
  end

  // Pipeline shift; a stall freezes every stage, clr only drops the valid bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        chan_q[i] <= '0;
        ovf_q[i]  <= 1'b0;
      end
    end else if (clr) begin
      valid_q <= '0;
    end else if (!stall_s) begin
      valid_q[0] <= accept_s;
      if (accept_s) begin
        data_q[0] <= res_d;
        chan_q[0] <= in_chan;
        ovf_q[0]  <= ovf_d;
      end else begin
        data_q[0] <= data_q[0];
      end
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
        chan_q[i]  <= chan_q[i-1];
        ovf_q[i]   <= ovf_q[i-1];
      end
    end else begin
      valid_q <= valid_q;
    end
  end

  // Accumulator write-back happens on the accept edge so the next beat sees it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc_q[c] <= '0;
      end
    end else if (clr) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (accept_s && acc_mode_s && (in_chan == CW'(c))) begin
          acc_q[c] <= res_d;
        end else begin
          acc_q[c] <= acc_q[c];
        end
      end
    end
  end

endmodule

// File: tb/tb_bar_acc_pipe.sv
// Self-checking bench for bar_acc_pipe: randomized and directed beats against a queue-based model.
module tb_bar_acc_pipe;
  localparam int WIDTH = 8;
  localparam int CHANNELS = 4;
  localparam int INC = 5;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] ch;
    logic       ovf;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst, clr, in_valid, in_mode, out_ready;
  logic       in_ready, out_valid, out_ovf;
  logic [1:0] in_chan, out_chan;
  logic [7:0] inp, out;

  int    n_checks = 0;
  int    n_fail = 0;
  int    acc_m [CHANNELS];
  beat_t exp_q [$];
  beat_t obs_q [$];
  logic  last_acc;

  bar_acc_pipe #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .INCREMENT(INC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_chan(in_chan), .inp(inp), .out_valid(out_valid),
    .out_ready(out_ready), .out_chan(out_chan), .out(out), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  // Advance one clock: sample handshakes before the edge, update model after it.
  task automatic tick();
    logic a_ev, o_ev, c_ev, m;
    logic [1:0] ch;
    logic [7:0] d;
    beat_t ob, e;
    int a, b, s;
    #1;
    a_ev = in_valid && in_ready;
    o_ev = out_valid && out_ready;
    c_ev = clr;
    ob = '{d: out, ch: out_chan, ovf: out_ovf};
    m = in_mode; ch = in_chan; d = inp;
    @(posedge clk);
    #1;
    if (o_ev) obs_q.push_back(ob);
    if (c_ev) begin
      while (exp_q.size() > obs_q.size()) void'(exp_q.pop_back());
      foreach (acc_m[i]) acc_m[i] = 0;
    end
    if (a_ev) begin
      if (m && (int'(ch) < CHANNELS)) begin a = acc_m[ch]; b = d; end
      else begin a = d; b = INC; end
      s = a + b;
      e.ch = ch;
      e.ovf = (s >= 256);
`ifdef BAR_ACC_PIPE_SATURATE_EN
      e.d = e.ovf ? 8'hFF : 8'(s % 256);
`else
      e.d = 8'(s % 256);
`endif
      if (m && (int'(ch) < CHANNELS)) acc_m[ch] = int'(e.d);
      exp_q.push_back(e);
    end
    last_acc = a_ev;
  endtask

  task automatic send(input logic m, input logic [1:0] ch, input logic [7:0] d);
    int n = 0;
    in_valid = 1'b1; in_mode = m; in_chan = ch; inp = d;
    do begin tick(); n++; end while (!last_acc && n < 20);
    n_checks++;
    if (!last_acc) begin n_fail++; $display("FAIL send_timeout got no accept in %0d cycles, need 1 accept", n); end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (obs_q.size() < exp_q.size() && n < 40) begin tick(); n++; end
    n_checks++;
    if (obs_q.size() < exp_q.size()) begin
      n_fail++; $display("FAIL drain_timeout got %0d beats, need %0d", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic clear_pulse();
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  task automatic test_reset();
    beat_t e, o;
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_chan = 2'd0; inp = 8'h00; out_ready = 1'b1;
    #3;
    n_checks++;
    if ({out_valid, in_ready, out, out_chan, out_ovf} !== 13'd0) begin
      n_fail++; $display("FAIL reset_state got v=%b rdy=%b out=%h ch=%0d ovf=%b, need all 0", out_valid, in_ready, out, out_chan, out_ovf);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    send(1'b1, 2'd0, 8'h33);
    send(1'b0, 2'd1, 8'h01);
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_midflight got v=%b rdy=%b, need v=0 rdy=0", out_valid, in_ready);
    end
    exp_q.delete(); obs_q.delete();
    foreach (acc_m[i]) acc_m[i] = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL reset_stale got %0d beats, need 0", obs_q.size()); end
    for (int c = 0; c < 4; c++) send(1'b1, 2'(c), 8'h01);
    drain();
    for (int c = 0; c < 4; c++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      n_checks++;
      if (o !== e || o.d !== 8'h01 || o.ch !== 2'(c)) begin
        n_fail++; $display("FAIL reset_acc_zero got d=%h ch=%0d, need d=01 ch=%0d", o.d, o.ch, c);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_mode0();
    beat_t e, o;
    send(1'b0, 2'd0, 8'h10);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mode0_early got v=%b, need 0", out_valid); end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out !== 8'h15 || out_ovf !== 1'b0 || out_chan !== 2'd0) begin
      n_fail++; $display("FAIL mode0_latency got v=%b out=%h ovf=%b, need v=1 out=15 ovf=0", out_valid, out, out_ovf);
    end
    send(1'b0, 2'd0, 8'hFD);
    tick();
    n_checks++;
`ifdef BAR_ACC_PIPE_SATURATE_EN
    if (out !== 8'hFF || out_ovf !== 1'b1) begin
      n_fail++; $display("FAIL mode0_sat got out=%h ovf=%b, need FF 1", out, out_ovf);
    end
`else
    if (out !== 8'h02 || out_ovf !== 1'b1) begin
      n_fail++; $display("FAIL mode0_wrap got out=%h ovf=%b, need 02 1", out, out_ovf);
    end
`endif
    for (int i = 0; i < 20; i++) send(1'b0, 2'($urandom_range(0, 3)), 8'($urandom));
    drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : ~e;
      n_checks++;
      if (o !== e) begin
        n_fail++; $display("FAIL mode0_stream got d=%h ch=%0d ovf=%b, need d=%h ch=%0d ovf=%b", o.d, o.ch, o.ovf, e.d, e.ch, e.ovf);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    beat_t o, e;
    logic [7:0] ed [5] = '{8'd3, 8'd7, 8'd12, 8'd9, 8'd13};
    logic [1:0] ec [5] = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd2};
    clear_pulse();
    send(1'b1, 2'd2, 8'd3);
    send(1'b1, 2'd2, 8'd4);
    send(1'b1, 2'd2, 8'd5);
    send(1'b1, 2'd1, 8'd9);
    send(1'b1, 2'd2, 8'd1);
    drain();
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      n_checks++;
      if (o !== e || o.d !== ed[i] || o.ch !== ec[i] || o.ovf !== 1'b0) begin
        n_fail++; $display("FAIL b2b_beat%0d got d=%0d ch=%0d, need d=%0d ch=%0d", i, o.d, o.ch, ed[i], ec[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_backpressure();
    beat_t o, e;
    int idx = 1;
    int stalls = 0;
    logic [7:0] held;
    logic prev_stall = 1'b0;
    in_mode = 1'b0;
    for (int cyc = 0; cyc < 60 && obs_q.size() < 10; cyc++) begin
      in_valid = (idx <= 10); inp = 8'(idx); in_chan = 2'(idx % 4);
      out_ready = !(cyc >= 4 && cyc < 7);
      #1;
      if (out_valid && !out_ready) begin
        stalls++;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready got %b, need 0", in_ready); end
        if (prev_stall) begin
          n_checks++;
          if (out !== held) begin n_fail++; $display("FAIL bp_hold got %h, need %h", out, held); end
        end
        held = out;
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      tick();
      if (last_acc) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (stalls != 3) begin n_fail++; $display("FAIL bp_stall_cycles got %0d, need 3", stalls); end
    n_checks++;
    if (obs_q.size() != 10) begin n_fail++; $display("FAIL bp_count got %0d, need 10", obs_q.size()); end
    for (int i = 1; i <= 10; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      n_checks++;
      if (o !== e || o.d !== 8'(i + INC)) begin
        n_fail++; $display("FAIL bp_order%0d got %0d, need %0d", i, o.d, i + INC);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_clr();
    beat_t o, e;
    out_ready = 1'b1;
    send(1'b1, 2'd3, 8'h11);
    send(1'b1, 2'd3, 8'h22);
    in_valid = 1'b1; in_mode = 1'b1; in_chan = 2'd0; inp = 8'h44; clr = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL clr_ready got %b, need 0", in_ready); end
    tick();
    clr = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_flush got v=%b, need 0", out_valid); end
    send(1'b1, 2'd3, 8'd7);
    send(1'b1, 2'd0, 8'd7);
    drain();
    n_checks++;
    if (exp_q.size() != 3 || obs_q.size() != 3) begin
      n_fail++; $display("FAIL clr_count got %0d beats, need 3", obs_q.size());
    end
    for (int i = 0; i < 3 && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : ~e;
      n_checks++;
      if (o !== e || (i > 0 && o.d !== 8'd7)) begin
        n_fail++; $display("FAIL clr_beat%0d got d=%h ch=%0d, need d=%h ch=%0d", i, o.d, o.ch, e.d, e.ch);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_overflow();
    beat_t o, e;
`ifdef BAR_ACC_PIPE_SATURATE_EN
    logic [7:0] ed [3] = '{8'hF0, 8'hFF, 8'hFF};
    logic       eo [3] = '{1'b0, 1'b1, 1'b1};
`else
    logic [7:0] ed [3] = '{8'hF0, 8'h10, 8'h11};
    logic       eo [3] = '{1'b0, 1'b1, 1'b0};
`endif
    clear_pulse();
    send(1'b1, 2'd0, 8'hF0);
    send(1'b1, 2'd0, 8'h20);
    send(1'b1, 2'd0, 8'h01);
    drain();
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      n_checks++;
      if (o !== e || o.d !== ed[i] || o.ovf !== eo[i]) begin
        n_fail++; $display("FAIL ovf_beat%0d got d=%h ovf=%b, need d=%h ovf=%b", i, o.d, o.ovf, ed[i], eo[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    beat_t o, e;
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_mode = 1'($urandom);
      in_chan = 2'($urandom);
      inp = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 49) == 0);
      tick();
    end
    clr = 1'b0; out_ready = 1'b1;
    drain();
    n_checks++;
    if (exp_q.size() != obs_q.size()) begin
      n_fail++; $display("FAIL rand_count got %0d beats, need %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : ~e;
      n_checks++;
      if (o !== e) begin
        n_fail++; $display("FAIL rand_beat got d=%h ch=%0d ovf=%b, need d=%h ch=%0d ovf=%b", o.d, o.ch, o.ovf, e.d, e.ch, e.ovf);
      end
    end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_back_to_back();
    test_backpressure();
    test_clr();
    test_overflow();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got simulation time limit, need completion");
    $fatal(1, "watchdog");
  end
endmodule
